mem_port_arbiter: RTL and testbench

- Shares the single-ported unified instruction/data memory between the IF stage (fetch) and the LSU of the 5-stage RISCV core.
- Sequences one memory transaction at a time over a req/gnt/rvalid protocol.
- Drives per-requester stall outputs that are OR-ed with the hazard stall into the pipeline enables.
- LSU has priority; a starvation counter bounds how long IF can be locked out.

---
 rtl/mem_port_arbiter.sv | 172 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares the single-ported unified I/D memory between instruction fetch and the LSU.
// One transaction at a time: IDLE -> REQ (until gnt) -> WAIT_RVALID (until rvalid) -> IDLE.
module mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    if_req_ip,
    input  logic [ADDR_WIDTH-1:0]   if_addr_ip,
    output logic                    if_gnt_op,
    output logic                    if_rvalid_op,
    output logic [DATA_WIDTH-1:0]   if_rdata_op,
    input  logic                    lsu_req_ip,
    input  logic                    lsu_we_ip,
    input  logic [DATA_WIDTH/8-1:0] lsu_be_ip,
    input  logic [ADDR_WIDTH-1:0]   lsu_addr_ip,
    input  logic [DATA_WIDTH-1:0]   lsu_wdata_ip,
    output logic                    lsu_gnt_op,
    output logic                    lsu_rvalid_op,
    output logic [DATA_WIDTH-1:0]   lsu_rdata_op,
    output logic                    mem_req_op,
    output logic                    mem_we_op,
    output logic [DATA_WIDTH/8-1:0] mem_be_op,
    output logic [ADDR_WIDTH-1:0]   mem_addr_op,
    output logic [DATA_WIDTH-1:0]   mem_wdata_op,
    input  logic                    mem_gnt_ip,
    input  logic                    mem_rvalid_ip,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_ip,
    output logic                    if_stall_op,
    output logic                    lsu_stall_op,
    output logic                    protocol_err_op
);
    localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8;
    localparam int unsigned CNT_WIDTH = (STARVE_LIMIT == 0) ? 1 : $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_REQ         = 2'd1,
        ST_WAIT_RVALID = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic                  owner_lsu_q, owner_lsu_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic [BE_WIDTH-1:0]   be_q, be_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [CNT_WIDTH-1:0]  starve_cnt_q, starve_cnt_d;
    logic                  protocol_err_q, protocol_err_d;

    logic starve_hit;
    logic lsu_win;
    logic if_win;
    logic gnt_fire;
    logic rsp_fire;
    logic busy;

    // With a zero limit IF never overrides a contending LSU request.
    assign starve_hit = (STARVE_LIMIT != 0) && (starve_cnt_q == CNT_WIDTH'(STARVE_LIMIT));

    always_comb begin
        state_d        = state_q;
        owner_lsu_d    = owner_lsu_q;
        addr_d         = addr_q;
        we_d           = we_q;
        be_d           = be_q;
        wdata_d        = wdata_q;
        starve_cnt_d   = starve_cnt_q;
        protocol_err_d = protocol_err_q;
        lsu_win        = 1'b0;
        if_win         = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                lsu_win = lsu_req_ip && !(if_req_ip && starve_hit);
                if_win  = if_req_ip && !lsu_win;
                if (mem_rvalid_ip) begin
                    protocol_err_d = 1'b1;
                end
                if (lsu_win) begin
                    state_d     = ST_REQ;
                    owner_lsu_d = 1'b1;
                    addr_d      = lsu_addr_ip;
                    we_d        = lsu_we_ip;
                    be_d        = lsu_be_ip;
                    wdata_d     = lsu_wdata_ip;
                    if (!if_req_ip) begin
                        starve_cnt_d = '0;
                    end else if (starve_cnt_q != CNT_WIDTH'(STARVE_LIMIT)) begin
                        starve_cnt_d = starve_cnt_q + CNT_WIDTH'(1);
                    end
                end else if (if_win) begin
                    state_d      = ST_REQ;
                    owner_lsu_d  = 1'b0;
                    addr_d       = if_addr_ip;
                    we_d         = 1'b0;
                    be_d         = '1;
                    wdata_d      = '0;
                    starve_cnt_d = '0;
                end else begin
                    starve_cnt_d = '0;
                end
            end
            ST_REQ: begin
                if (mem_rvalid_ip) begin
                    protocol_err_d = 1'b1;
                end
                if (mem_gnt_ip) begin
                    state_d = ST_WAIT_RVALID;
                end
            end
            ST_WAIT_RVALID: begin
                if (mem_rvalid_ip) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            owner_lsu_q    <= 1'b0;
            addr_q         <= '0;
            we_q           <= 1'b0;
            be_q           <= '0;
            wdata_q        <= '0;
            starve_cnt_q   <= '0;
            protocol_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            owner_lsu_q    <= owner_lsu_d;
            addr_q         <= addr_d;
            we_q           <= we_d;
            be_q           <= be_d;
            wdata_q        <= wdata_d;
            starve_cnt_q   <= starve_cnt_d;
            protocol_err_q <= protocol_err_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign gnt_fire = (state_q == ST_REQ) && mem_gnt_ip;
    assign rsp_fire = (state_q == ST_WAIT_RVALID) && mem_rvalid_ip;

    assign mem_req_op      = (state_q == ST_REQ);
    assign mem_we_op       = we_q;
    assign mem_be_op       = be_q;
    assign mem_addr_op     = addr_q;
    assign mem_wdata_op    = wdata_q;
    assign protocol_err_op = protocol_err_q;

    assign if_gnt_op     = gnt_fire && !owner_lsu_q;
    assign lsu_gnt_op    = gnt_fire && owner_lsu_q;
    assign if_rvalid_op  = rsp_fire && !owner_lsu_q;
    assign lsu_rvalid_op = rsp_fire && owner_lsu_q;

    // Read data and stalls are forced low while reset is held so every output reads 0.
    assign if_rdata_op  = reset ? mem_rdata_ip : '0;
    assign lsu_rdata_op = reset ? mem_rdata_ip : '0;

    assign if_stall_op  = reset && ((if_req_ip && !if_rvalid_op) ||
                                    (busy && !owner_lsu_q && !if_rvalid_op));
    assign lsu_stall_op = reset && ((lsu_req_ip && !lsu_rvalid_op) ||
                                    (busy && owner_lsu_q && !lsu_rvalid_op));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;
    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned BW  = DW / 8;
    localparam int unsigned LIM = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req_ip;
    logic [AW-1:0] if_addr_ip;
    logic          if_gnt_op;
    logic          if_rvalid_op;
    logic [DW-1:0] if_rdata_op;
    logic          lsu_req_ip;
    logic          lsu_we_ip;
    logic [BW-1:0] lsu_be_ip;
    logic [AW-1:0] lsu_addr_ip;
    logic [DW-1:0] lsu_wdata_ip;
    logic          lsu_gnt_op;
    logic          lsu_rvalid_op;
    logic [DW-1:0] lsu_rdata_op;
    logic          mem_req_op;
    logic          mem_we_op;
    logic [BW-1:0] mem_be_op;
    logic [AW-1:0] mem_addr_op;
    logic [DW-1:0] mem_wdata_op;
    logic          mem_gnt_ip;
    logic          mem_rvalid_ip;
    logic [DW-1:0] mem_rdata_ip;
    logic          if_stall_op;
    logic          lsu_stall_op;
    logic          protocol_err_op;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .STARVE_LIMIT(LIM)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .if_req_ip      (if_req_ip),
        .if_addr_ip     (if_addr_ip),
        .if_gnt_op      (if_gnt_op),
        .if_rvalid_op   (if_rvalid_op),
        .if_rdata_op    (if_rdata_op),
        .lsu_req_ip     (lsu_req_ip),
        .lsu_we_ip      (lsu_we_ip),
        .lsu_be_ip      (lsu_be_ip),
        .lsu_addr_ip    (lsu_addr_ip),
        .lsu_wdata_ip   (lsu_wdata_ip),
        .lsu_gnt_op     (lsu_gnt_op),
        .lsu_rvalid_op  (lsu_rvalid_op),
        .lsu_rdata_op   (lsu_rdata_op),
        .mem_req_op     (mem_req_op),
        .mem_we_op      (mem_we_op),
        .mem_be_op      (mem_be_op),
        .mem_addr_op    (mem_addr_op),
        .mem_wdata_op   (mem_wdata_op),
        .mem_gnt_ip     (mem_gnt_ip),
        .mem_rvalid_ip  (mem_rvalid_ip),
        .mem_rdata_ip   (mem_rdata_ip),
        .if_stall_op    (if_stall_op),
        .lsu_stall_op   (lsu_stall_op),
        .protocol_err_op(protocol_err_op)
    );

    int checks   = 0;
    int failures = 0;

    // Transaction-level model: one outstanding access, granted or not yet granted.
    bit            m_busy;
    bit            m_granted;
    bit            m_lsu;
    bit            m_we;
    bit            m_err;
    logic [AW-1:0] m_addr;
    logic [BW-1:0] m_be;
    logic [DW-1:0] m_wdata;
    int unsigned   m_cnt;
    bit            win_log[$];
    bit            last_if_gnt;
    bit            last_lsu_gnt;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy    = 1'b0;
        m_granted = 1'b0;
        m_lsu     = 1'b0;
        m_we      = 1'b0;
        m_err     = 1'b0;
        m_addr    = '0;
        m_be      = '0;
        m_wdata   = '0;
        m_cnt     = 0;
    endtask

    // Compare every DUT output with the model, mid-cycle.
    task automatic sample();
        logic e_req, e_ig, e_lg, e_ir, e_lr, e_is, e_ls;
        @(negedge clk);
        if (!reset) model_reset();
        e_req = reset && m_busy && !m_granted;
        e_ig  = e_req && mem_gnt_ip && !m_lsu;
        e_lg  = e_req && mem_gnt_ip && m_lsu;
        e_ir  = reset && m_busy && m_granted && mem_rvalid_ip && !m_lsu;
        e_lr  = reset && m_busy && m_granted && mem_rvalid_ip && m_lsu;
        e_is  = reset && ((if_req_ip && !e_ir) || (m_busy && !m_lsu && !e_ir));
        e_ls  = reset && ((lsu_req_ip && !e_lr) || (m_busy && m_lsu && !e_lr));
        chk1("mdl_mem_req", mem_req_op, e_req);
        chk1("mdl_if_gnt", if_gnt_op, e_ig);
        chk1("mdl_lsu_gnt", lsu_gnt_op, e_lg);
        chk1("mdl_if_rvalid", if_rvalid_op, e_ir);
        chk1("mdl_lsu_rvalid", lsu_rvalid_op, e_lr);
        chk1("mdl_if_stall", if_stall_op, e_is);
        chk1("mdl_lsu_stall", lsu_stall_op, e_ls);
        chk1("mdl_protocol_err", protocol_err_op, m_err);
        chk32("mdl_if_rdata", if_rdata_op, reset ? mem_rdata_ip : 32'h0);
        chk32("mdl_lsu_rdata", lsu_rdata_op, reset ? mem_rdata_ip : 32'h0);
        if (e_req || !reset) begin
            chk32("mdl_mem_addr", mem_addr_op, m_addr);
            chk1("mdl_mem_we", mem_we_op, m_we);
            chk32("mdl_mem_be", 32'(mem_be_op), 32'(m_be));
            if (m_we || !reset) chk32("mdl_mem_wdata", mem_wdata_op, m_wdata);
        end
        last_if_gnt  = e_ig;
        last_lsu_gnt = e_lg;
    endtask

    // Advance the model with this cycle's inputs, then step to just after the clock edge.
    task automatic advance();
        bit lsu_wins, if_wins;
        if (!reset) begin
            model_reset();
        end else begin
            if (mem_rvalid_ip && !(m_busy && m_granted)) m_err = 1'b1;
            if (!m_busy) begin
                lsu_wins = lsu_req_ip && !(if_req_ip && LIM != 0 && m_cnt == LIM);
                if_wins  = if_req_ip && !lsu_wins;
                if (lsu_wins) begin
                    m_busy  = 1'b1;
                    m_lsu   = 1'b1;
                    m_addr  = lsu_addr_ip;
                    m_we    = lsu_we_ip;
                    m_be    = lsu_be_ip;
                    m_wdata = lsu_wdata_ip;
                    m_cnt   = if_req_ip ? ((m_cnt < LIM) ? m_cnt + 1 : m_cnt) : 0;
                    win_log.push_back(1'b1);
                end else if (if_wins) begin
                    m_busy  = 1'b1;
                    m_lsu   = 1'b0;
                    m_addr  = if_addr_ip;
                    m_we    = 1'b0;
                    m_be    = '1;
                    m_wdata = '0;
                    m_cnt   = 0;
                    win_log.push_back(1'b0);
                end else begin
                    m_cnt = 0;
                end
            end else if (!m_granted) begin
                if (mem_gnt_ip) m_granted = 1'b1;
            end else if (mem_rvalid_ip) begin
                m_busy    = 1'b0;
                m_granted = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // One complete transaction from IDLE; drop: 0 keep request, 1 drop after gnt, 2 drop in first REQ cycle.
    task automatic txn(input int gwait, input bit exp_lsu, input logic [AW-1:0] exp_addr,
                       input logic [DW-1:0] rdat, input int drop);
        logic          e_we;
        logic [BW-1:0] e_be;
        logic [DW-1:0] e_wd;
        e_we = exp_lsu ? lsu_we_ip : 1'b0;
        e_be = exp_lsu ? lsu_be_ip : '1;
        e_wd = lsu_wdata_ip;
        mem_gnt_ip    = 1'b0;
        mem_rvalid_ip = 1'b0;
        sample();
        chk1("arb_mem_req", mem_req_op, 1'b0);
        advance();
        for (int i = 0; i <= gwait; i++) begin
            mem_gnt_ip = (i == gwait);
            sample();
            chk1("req_mem_req", mem_req_op, 1'b1);
            chk32("req_addr", mem_addr_op, exp_addr);
            chk1("req_we", mem_we_op, e_we);
            chk32("req_be", 32'(mem_be_op), 32'(e_be));
            if (e_we) chk32("req_wdata", mem_wdata_op, e_wd);
            chk1("req_if_gnt", if_gnt_op, (i == gwait) && !exp_lsu);
            chk1("req_lsu_gnt", lsu_gnt_op, (i == gwait) && exp_lsu);
            if (exp_lsu && if_req_ip) chk1("req_if_stall", if_stall_op, 1'b1);
            if (drop == 2 && i == 0) begin
                if (exp_lsu) lsu_req_ip = 1'b0;
                else         if_req_ip  = 1'b0;
            end
            advance();
        end
        mem_gnt_ip = 1'b0;
        if (drop == 1) begin
            if (exp_lsu) lsu_req_ip = 1'b0;
            else         if_req_ip  = 1'b0;
        end
        mem_rvalid_ip = 1'b1;
        mem_rdata_ip  = rdat;
        sample();
        chk1("rsp_if_rvalid", if_rvalid_op, !exp_lsu);
        chk1("rsp_lsu_rvalid", lsu_rvalid_op, exp_lsu);
        chk32("rsp_rdata", exp_lsu ? lsu_rdata_op : if_rdata_op, rdat);
        if (exp_lsu && if_req_ip) chk1("rsp_if_stall", if_stall_op, 1'b1);
        advance();
        mem_rvalid_ip = 1'b0;
    endtask

    initial begin
        reset         = 1'b0;
        if_req_ip     = 1'b0;
        if_addr_ip    = '0;
        lsu_req_ip    = 1'b0;
        lsu_we_ip     = 1'b0;
        lsu_be_ip     = '0;
        lsu_addr_ip   = '0;
        lsu_wdata_ip  = '0;
        mem_gnt_ip    = 1'b0;
        mem_rvalid_ip = 1'b0;
        mem_rdata_ip  = 32'h5A5A_5A5A;
        last_if_gnt   = 1'b0;
        last_lsu_gnt  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;

        // Reset state: requests present but every output held low.
        if_req_ip  = 1'b1;
        lsu_req_ip = 1'b1;
        sample();
        chk1("rst_mem_req", mem_req_op, 1'b0);
        chk1("rst_if_stall", if_stall_op, 1'b0);
        chk1("rst_lsu_stall", lsu_stall_op, 1'b0);
        chk1("rst_err", protocol_err_op, 1'b0);
        chk32("rst_if_rdata", if_rdata_op, 32'h0);
        advance();
        if_req_ip  = 1'b0;
        lsu_req_ip = 1'b0;
        reset      = 1'b1;

        // Idle fetch with zero-wait memory.
        if_req_ip  = 1'b1;
        if_addr_ip = 32'h0000_0100;
        txn(0, 1'b0, 32'h0000_0100, 32'h0013_0093, 1);
        sample();
        chk1("fetch_if_stall_c3", if_stall_op, 1'b0);
        advance();

        // Simultaneous requests: LSU first, then IF.
        if_req_ip   = 1'b1;
        if_addr_ip  = 32'h0000_0400;
        lsu_req_ip  = 1'b1;
        lsu_we_ip   = 1'b0;
        lsu_be_ip   = 4'hF;
        lsu_addr_ip = 32'h0000_2000;
        txn(0, 1'b1, 32'h0000_2000, 32'hAAAA_5555, 1);
        txn(0, 1'b0, 32'h0000_0400, 32'h1234_5678, 1);

        // Starvation bound: four LSU wins, then IF, then LSU again.
        win_log.delete();
        lsu_req_ip  = 1'b1;
        lsu_addr_ip = 32'h0000_5000;
        if_req_ip   = 1'b1;
        if_addr_ip  = 32'h0000_0600;
        for (int k = 0; k < 6; k++) begin
            txn(0, k != 4, (k != 4) ? 32'h0000_5000 : 32'h0000_0600, $urandom, 0);
        end
        lsu_req_ip = 1'b0;
        if_req_ip  = 1'b0;
        chk32("starve_log_len", 32'(win_log.size()), 32'd6);
        for (int k = 0; k < 6 && k < win_log.size(); k++) begin
            chk1("starve_winner", win_log[k], k != 4);
        end

        // Store held off by memory for three cycles, request withdrawn after latching.
        lsu_req_ip   = 1'b1;
        lsu_we_ip    = 1'b1;
        lsu_be_ip    = 4'b0011;
        lsu_addr_ip  = 32'h0000_3000;
        lsu_wdata_ip = 32'hDEAD_BEEF;
        txn(3, 1'b1, 32'h0000_3000, 32'h0, 2);
        lsu_we_ip = 1'b0;

        // Stray response in IDLE.
        mem_rvalid_ip = 1'b1;
        sample();
        chk1("stray_if_rvalid", if_rvalid_op, 1'b0);
        chk1("stray_lsu_rvalid", lsu_rvalid_op, 1'b0);
        advance();
        mem_rvalid_ip = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sample();
            chk1("stray_err_sticky", protocol_err_op, 1'b1);
            advance();
        end

        // Reset asserted while waiting for the response.
        if_req_ip  = 1'b1;
        if_addr_ip = 32'h0000_0800;
        sample();
        advance();
        mem_gnt_ip = 1'b1;
        sample();
        advance();
        mem_gnt_ip   = 1'b0;
        if_req_ip    = 1'b0;
        mem_rdata_ip = 32'hCAFE_F00D;
        sample();
        chk1("wait_if_stall", if_stall_op, 1'b1);
        reset = 1'b0;
        #1;
        chk1("arst_mem_req", mem_req_op, 1'b0);
        chk1("arst_if_stall", if_stall_op, 1'b0);
        chk1("arst_err", protocol_err_op, 1'b0);
        chk32("arst_mem_addr", mem_addr_op, 32'h0);
        chk32("arst_if_rdata", if_rdata_op, 32'h0);
        chk1("arst_if_rvalid", if_rvalid_op, 1'b0);
        advance();
        reset      = 1'b1;
        if_req_ip  = 1'b1;
        if_addr_ip = 32'h0000_0900;
        txn(0, 1'b0, 32'h0000_0900, 32'h0000_1234, 1);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            if (!if_req_ip || last_if_gnt) begin
                if_req_ip  = ($urandom_range(0, 99) < 40);
                if_addr_ip = $urandom & 32'hFFFF_FFFC;
            end
            if (!lsu_req_ip || last_lsu_gnt) begin
                lsu_req_ip   = ($urandom_range(0, 99) < 40);
                lsu_we_ip    = 1'($urandom_range(0, 1));
                lsu_be_ip    = BW'($urandom);
                lsu_addr_ip  = $urandom;
                lsu_wdata_ip = $urandom;
            end
            mem_gnt_ip    = m_busy && !m_granted && ($urandom_range(0, 99) < 60);
            mem_rvalid_ip = m_busy && m_granted && ($urandom_range(0, 99) < 50);
            mem_rdata_ip  = $urandom;
            sample();
            advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
